branch_ctrl: RTL and testbench

- ID-stage branch resolution unit for the 16-bit pipelined core.
- It consumes the committed Z/V/N flags produced by the EX-stage flag register, evaluates B/BR conditions, and drives the PC redirect and the IF/ID flush.
- It stalls the front end while an older instruction in EX or MEM is about to change the flags or the BR source register.
- It also owns HLT detection and three saturating performance counters.

---
 rtl/branch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution for the 16-bit pipelined core.
// Evaluates B/BR conditions against the committed {Z,V,N} flags, redirects
// the PC and flushes IF/ID on a taken branch, stalls the front end while an
// older EX/MEM instruction is about to change the flags or the BR source
// register, detects HLT, and keeps three saturating performance counters.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   id_valid, id_instr    instruction currently in ID
//   id_pc_plus2           PC+2 of the ID instruction (base for B targets)
//   id_rs_data            bypassed read of id_instr[7:4] (BR target)
//   ex_instr              instruction in EX (flag-writer detection)
//   ex_reg_wr, ex_rd      EX register write-back
//   mem_reg_wr, mem_rd    MEM register write-back
//   flags                 committed {Z,V,N}
//   stall                 hold PC and IF/ID, bubble into ID/EX (same cycle)
//   pc_redirect           load pc_target into PC (same cycle)
//   pc_target             computed branch target
//   flush_ifid            squash IF/ID at the next edge (same cycle)
//   halt                  core halted (registered)
//   br_cnt, taken_cnt     resolved / taken branches (registered, saturating)
//   stall_cnt             branch-hazard stall cycles (registered, saturating)
module branch_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] NOP_INSTR = 16'h4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic [15:0]      id_pc_plus2,
    input  logic [15:0]      id_rs_data,
    input  logic [15:0]      ex_instr,
    input  logic             ex_reg_wr,
    input  logic [3:0]       ex_rd,
    input  logic             mem_reg_wr,
    input  logic [3:0]       mem_rd,
    input  logic [2:0]       flags,
    output logic             stall,
    output logic             pc_redirect,
    output logic [15:0]      pc_target,
    output logic             flush_ifid,
    output logic             halt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_B   = 4'hC;
    localparam logic [OP_W-1:0] OP_BR  = 4'hD;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;
    localparam logic [OP_W-1:0] OP_LAST_FLAG_WRITER = 4'h2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    logic [OP_W-1:0] id_op;
    logic [OP_W-1:0] ex_op;
    logic [2:0]      ccc;
    logic [3:0]      rs;
    logic            flag_z, flag_v, flag_n;
    logic            is_b, is_brr, is_br, is_hlt;
    logic            cond_true;
    logic            flag_hazard, reg_hazard, hazard;
    logic [15:0]     b_off;
    logic            resolve_c;
    logic            stall_c;
    logic            count_stall_c;

    assign id_op  = id_instr[15:12];
    assign ex_op  = ex_instr[15:12];
    assign ccc    = id_instr[11:9];
    assign rs     = id_instr[7:4];
    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    assign is_b   = id_valid && (id_op == OP_B);
    assign is_brr = id_valid && (id_op == OP_BR);
    assign is_br  = is_b || is_brr;
    assign is_hlt = id_valid && (id_op == OP_HLT);

    // Branch condition decode
    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            3'b000:  cond_true = !flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z && !flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
            3'b101:  cond_true = flag_z || flag_n;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Unconditional branches never wait on flags; bubbles never write flags
    assign flag_hazard = (ccc != 3'b111)
                      && (ex_instr != 16'h0000)
                      && (ex_instr != NOP_INSTR)
                      && (ex_op <= OP_LAST_FLAG_WRITER);

    // r0 is hard-wired, so a write to it can never change the BR source
    assign reg_hazard = is_brr && (rs != 4'd0)
                     && ((ex_reg_wr && (ex_rd == rs))
                      || (mem_reg_wr && (mem_rd == rs)));

    assign hazard = flag_hazard || reg_hazard;

    // Target: sign-extended word offset for B, register value for BR
    assign b_off     = {{6{id_instr[8]}}, id_instr[8:0], 1'b0};
    assign pc_target = (id_op == OP_BR) ? id_rs_data : (id_pc_plus2 + b_off);

    // Same-cycle resolve/stall decode; reset masks everything
    always_comb begin
        resolve_c     = 1'b0;
        stall_c       = 1'b0;
        count_stall_c = 1'b0;
        if (!rst) begin
            case (state)
                IDLE, WAIT: begin
                    if (is_br) begin
                        if (hazard) begin
                            stall_c       = 1'b1;
                            count_stall_c = 1'b1;
                        end else begin
                            resolve_c = 1'b1;
                        end
                    end
                end
                HALTED:  stall_c = 1'b1;
                default: stall_c = 1'b0;
            endcase
        end
    end

    assign stall       = stall_c;
    assign pc_redirect = resolve_c && cond_true;
    assign flush_ifid  = resolve_c && cond_true;
    assign halt        = (state == HALTED);

    // State register and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_br && hazard)
                        state <= WAIT;
                    else if (is_hlt)
                        state <= HALTED;
                end
                // Leaving WAIT without a branch in ID drops it unresolved
                WAIT: begin
                    if (!(is_br && hazard))
                        state <= IDLE;
                end
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase

            if (resolve_c && (br_cnt != '1))
                br_cnt <= br_cnt + CNT_W'(1);
            if (resolve_c && cond_true && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (count_stall_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic, each
// cycle checked against a rule-level reference model.
module tb_branch_ctrl;

    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [15:0]      id_instr;
    logic [15:0]      id_pc_plus2;
    logic [15:0]      id_rs_data;
    logic [15:0]      ex_instr;
    logic             ex_reg_wr;
    logic [3:0]       ex_rd;
    logic             mem_reg_wr;
    logic [3:0]       mem_rd;
    logic [2:0]       flags;
    logic             stall;
    logic             pc_redirect;
    logic [15:0]      pc_target;
    logic             flush_ifid;
    logic             halt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    branch_ctrl #(.CNT_W(CNT_W), .NOP_INSTR(16'h4000)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus2(id_pc_plus2), .id_rs_data(id_rs_data),
        .ex_instr(ex_instr), .ex_reg_wr(ex_reg_wr), .ex_rd(ex_rd),
        .mem_reg_wr(mem_reg_wr), .mem_rd(mem_rd), .flags(flags),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .flush_ifid(flush_ifid), .halt(halt),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit m_halted    = 1'b0;
    bit m_was_stall = 1'b0;
    int m_br        = 0;
    int m_taken     = 0;
    int m_stall     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_of(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Compare one cycle at the falling edge, then advance the model
    task automatic step();
        logic [3:0]  opc;
        logic [2:0]  c;
        logic [3:0]  r;
        logic [8:0]  imm;
        bit          br, haz, cnd, e_stall, e_redir, chk_targ;
        int          off;
        logic [15:0] e_targ;
        @(negedge clk);
        opc = id_instr[15:12];
        c   = id_instr[11:9];
        r   = id_instr[7:4];
        imm = id_instr[8:0];
        br  = id_valid && (opc == 4'hC || opc == 4'hD);
        haz = ((c != 3'd7) && ex_instr != 16'h0000 && ex_instr != 16'h4000
               && ex_instr[15:12] <= 4'h2)
           || (opc == 4'hD && r != 4'd0
               && ((ex_reg_wr && ex_rd == r) || (mem_reg_wr && mem_rd == r)));
        cnd = cond_of(c, flags);
        off = imm[8] ? int'(imm) - 512 : int'(imm);
        e_targ   = (opc == 4'hD) ? id_rs_data : 16'((int'(id_pc_plus2) + 2 * off) & 32'hFFFF);
        e_stall  = 1'b0;
        e_redir  = 1'b0;
        chk_targ = 1'b0;
        if (!rst) begin
            if (m_halted)
                e_stall = 1'b1;
            else if (br) begin
                chk_targ = 1'b1;
                if (haz) e_stall = 1'b1;
                else     e_redir = cnd;
            end
        end
        check("stall",       32'(stall),       32'(e_stall));
        check("pc_redirect", 32'(pc_redirect), 32'(e_redir));
        check("flush_ifid",  32'(flush_ifid),  32'(e_redir));
        check("halt",        32'(halt),        32'(m_halted));
        check("br_cnt",      32'(br_cnt),      32'(m_br));
        check("taken_cnt",   32'(taken_cnt),   32'(m_taken));
        check("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        if (chk_targ) check("pc_target", 32'(pc_target), 32'(e_targ));
        // Model update for the coming edge
        if (rst) begin
            m_halted = 0; m_was_stall = 0; m_br = 0; m_taken = 0; m_stall = 0;
        end else if (!m_halted) begin
            if (br && haz) begin
                if (m_stall < CNT_MAX) m_stall++;
                m_was_stall = 1;
            end else begin
                if (br) begin
                    if (m_br < CNT_MAX) m_br++;
                    if (cnd && m_taken < CNT_MAX) m_taken++;
                end else if (id_valid && opc == 4'hF && !m_was_stall) begin
                    m_halted = 1;
                end
                m_was_stall = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        id_valid = 0; id_instr = 16'h4000; id_pc_plus2 = 0; id_rs_data = 0;
        ex_instr = 16'h4000; ex_reg_wr = 0; ex_rd = 0; mem_reg_wr = 0; mem_rd = 0;
        flags = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        quiet_inputs();
        step();
        rst = 0;
        #1;
        check("reset_halt",  32'(halt),  32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_brcnt", 32'(br_cnt), 32'd0);

        // Taken branch, no hazard
        flags = 3'b100; id_valid = 1; id_instr = 16'hC204; id_pc_plus2 = 16'h0010;
        #1;
        check("t1_redirect", 32'(pc_redirect), 32'd1);
        check("t1_target",   32'(pc_target),   32'h0018);
        step();
        quiet_inputs();
        #1;
        check("t1_br_cnt",    32'(br_cnt),    32'd1);
        check("t1_taken_cnt", 32'(taken_cnt), 32'd1);
        step();

        // Flag hazard then resolve
        do_reset();
        id_valid = 1; id_instr = 16'hC003; id_pc_plus2 = 16'h0100; ex_instr = 16'h0123;
        #1;
        check("t2_stall",    32'(stall),       32'd1);
        check("t2_noredir",  32'(pc_redirect), 32'd0);
        step();
        ex_instr = 16'h4000; flags = 3'b000;
        #1;
        check("t2_redirect", 32'(pc_redirect), 32'd1);
        step();
        quiet_inputs();
        #1;
        check("t2_stall_cnt", 32'(stall_cnt), 32'd1);
        check("t2_br_cnt",    32'(br_cnt),    32'd1);

        // Register hazard on BR source, EX then MEM
        do_reset();
        id_valid = 1; id_instr = 16'hDE30; id_rs_data = 16'hBEEF;
        ex_reg_wr = 1; ex_rd = 3;
        step();
        ex_reg_wr = 0; mem_reg_wr = 1; mem_rd = 3;
        step();
        mem_reg_wr = 0;
        #1;
        check("t3_redirect", 32'(pc_redirect), 32'd1);
        check("t3_target",   32'(pc_target),   32'hBEEF);
        step();
        quiet_inputs();
        #1;
        check("t3_stall_cnt", 32'(stall_cnt), 32'd2);

        // Not-taken (V=0) and wrap-around target
        id_valid = 1; id_instr = 16'hCC00; flags = 3'b000;
        step();
        id_instr = 16'hCFFF; id_pc_plus2 = 16'h0000;
        #1;
        check("t4_wrap_target", 32'(pc_target), 32'hFFFE);
        step();
        quiet_inputs();
        step();

        // Halt: held, branches ignored, cleared by reset
        id_valid = 1; id_instr = 16'hF000;
        step();
        id_instr = 16'hC204; flags = 3'b100;
        for (int i = 0; i < 10; i++) step();
        check("t5_halt", 32'(halt), 32'd1);
        quiet_inputs();
        do_reset();
        check("t5_unhalt", 32'(halt), 32'd0);

        // Reset during WAIT
        id_valid = 1; id_instr = 16'hC000; ex_instr = 16'h1000;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        quiet_inputs();
        #1;
        check("t6_stall",     32'(stall),     32'd0);
        check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        step();

        // External flush while waiting: dropped without resolve
        id_valid = 1; id_instr = 16'hC000; ex_instr = 16'h0123;
        step();
        id_valid = 0;
        step();
        quiet_inputs();
        #1;
        check("t7_br_cnt", 32'(br_cnt), 32'd0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int sel;
            rst      = ($urandom_range(0, 39) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 39);
            id_instr = 16'($urandom);
            if (sel < 16)      id_instr[15:12] = 4'hC;
            else if (sel < 30) id_instr[15:12] = 4'hD;
            else if (sel == 30) id_instr[15:12] = 4'hF;
            else               id_instr[15:12] = 4'($urandom_range(0, 11));
            id_instr[7:4] = 4'($urandom_range(0, 3));
            id_pc_plus2 = 16'($urandom);
            id_rs_data  = 16'($urandom);
            sel = $urandom_range(0, 3);
            case (sel)
                0: ex_instr = 16'h0000;
                1: ex_instr = 16'h4000;
                2: ex_instr = {4'($urandom_range(0, 2)), 12'($urandom)};
                default: ex_instr = 16'($urandom);
            endcase
            ex_reg_wr  = 1'($urandom);
            ex_rd      = 4'($urandom_range(0, 3));
            mem_reg_wr = 1'($urandom);
            mem_rd     = 4'($urandom_range(0, 3));
            flags      = 3'($urandom);
            step();
        end
        rst = 0;

        // Saturation of stall_cnt
        quiet_inputs();
        do_reset();
        id_valid = 1; id_instr = 16'hC000; ex_instr = 16'h0123;
        for (int i = 0; i < 65539; i++) step();
        check("t8_stall_sat", 32'(stall_cnt), 32'hFFFF);
        check("t8_still_stall", 32'(stall), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
